// File: rtl/clock_divide_meter_if.sv
// Measured divided clock plus the measurement results of clock_divide_meter.
interface clock_divide_meter_if #(
  parameter int CNT_W = 8
);
  logic             sig_in;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] low_time;
  logic [CNT_W:0]   period;
  logic [5:0]       div_factor;
  logic             factor_ok;
  logic             meas_valid;
  logic             locked;
  logic             stalled;

  modport master (
    input  sig_in,
    output high_time, low_time, period, div_factor,
    output factor_ok, meas_valid, locked, stalled
  );

  modport slave (
    output sig_in,
    input  high_time, low_time, period, div_factor,
    input  factor_ok, meas_valid, locked, stalled
  );
endinterface

// File: rtl/clock_divide_meter.sv
// Measures high/low time and period of a looped-back divided clock and
// recovers the divide factor (half-period = factor + 2) that produced it.
module clock_divide_meter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clock_divide_meter_if.master bus
);

  localparam logic [1:0] WAIT_RISE = 2'd0;
  localparam logic [1:0] HIGH      = 2'd1;
  localparam logic [1:0] LOW       = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_MIN   = CNT_W'(2);
  localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(65);

  logic             s1, s2, s3;
  logic             rise_s, fall_s, strobe, timeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_cap;
  logic [CNT_W:0]   prev_period;
  logic             have_prev;
  logic [CNT_W:0]   new_period;
  logic [5:0]       div_next;
  logic             ok_next;
  logic             lock_next;

  logic [CNT_W-1:0] high_time_r;
  logic [CNT_W-1:0] low_time_r;
  logic [CNT_W:0]   period_r;
  logic [5:0]       div_factor_r;
  logic             factor_ok_r;
  logic             meas_valid_r;
  logic             locked_r;
  logic             stalled_r;

  assign rise_s  = s2 & ~s3;
  assign fall_s  = ~s2 & s3;
  assign strobe  = rise_s | fall_s;
  // A strobe landing on the timeout cycle takes priority over the stall.
  assign timeout = ~strobe && (cnt == TMO);

  assign new_period = {1'b0, high_cap} + {1'b0, cnt};
  assign ok_next    = (high_cap == cnt) && (high_cap >= H_MIN) && (high_cap <= H_MAX);
  assign lock_next  = have_prev && (new_period == prev_period);

  always_comb begin
    div_next = 6'd0;
    if (high_cap > H_MAX)
      div_next = 6'd63;
    else if (high_cap >= H_MIN)
      div_next = 6'(high_cap - H_MIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      state        <= WAIT_RISE;
      cnt          <= '0;
      high_cap     <= '0;
      prev_period  <= '0;
      have_prev    <= 1'b0;
      high_time_r  <= '0;
      low_time_r   <= '0;
      period_r     <= '0;
      div_factor_r <= '0;
      factor_ok_r  <= 1'b0;
      meas_valid_r <= 1'b0;
      locked_r     <= 1'b0;
      stalled_r    <= 1'b0;
    end else begin
      s1           <= bus.sig_in;
      s2           <= s1;
      s3           <= s2;
      meas_valid_r <= 1'b0;

      if (strobe || timeout)
        cnt <= ONE;
      else if (cnt != CNT_MAX)
        cnt <= cnt + ONE;

      case (state)
        WAIT_RISE: if (rise_s) state <= HIGH;
        HIGH: begin
          if (fall_s) begin
            high_cap <= cnt;
            state    <= LOW;
          end
        end
        LOW: begin
          if (rise_s) begin
            high_time_r  <= high_cap;
            low_time_r   <= cnt;
            period_r     <= new_period;
            div_factor_r <= div_next;
            factor_ok_r  <= ok_next;
            locked_r     <= lock_next;
            prev_period  <= new_period;
            have_prev    <= 1'b1;
            meas_valid_r <= 1'b1;
            stalled_r    <= 1'b0;
            state        <= HIGH;
          end
        end
        default: state <= WAIT_RISE;
      endcase

      // Stall drops lock history but keeps the last measurement on the outputs.
      if (timeout) begin
        stalled_r <= 1'b1;
        locked_r  <= 1'b0;
        have_prev <= 1'b0;
        state     <= WAIT_RISE;
      end
    end
  end

  assign bus.high_time  = high_time_r;
  assign bus.low_time   = low_time_r;
  assign bus.period     = period_r;
  assign bus.div_factor = div_factor_r;
  assign bus.factor_ok  = factor_ok_r;
  assign bus.meas_valid = meas_valid_r;
  assign bus.locked     = locked_r;
  assign bus.stalled    = stalled_r;

endmodule

// File: doc/clock_divide_meter.md
Name: clock_divide_meter

Overview:
- Receive-side companion to the 4-channel selectable clock divider: takes the selected divided clock back in and measures its high time, low time and period in `clk` cycles.
- Recovers the 6-bit divide factor that produced the waveform.
- The divider toggles every F+2 clocks for factor F, so half-period H = F+2.
- Used on-chip for loopback self-check and for reading divider settings back out through the user IO.

Parameters:
- CNT_W, 8, width of phase counters and high/low time outputs; must be ≥ 7.
- TIMEOUT, 200, max `clk` cycles allowed in any single phase before declaring stall; must be ≤ 2^CNT_W-1.

Ports:
- clk  input  1  system clock; same clock that drives the divider.
- rst_n  input  1  synchronous reset, active-low; sampled on posedge `clk`.
- sig_in  input  1  divided clock under measurement; treated as asynchronous.
- high_time  output  CNT_W  clk cycles between last rise strobe and following fall strobe.
- low_time  output  CNT_W  clk cycles between last fall strobe and following rise strobe.
- period  output  CNT_W+1  high_time + low_time of the last complete cycle.
- div_factor  output  6  recovered factor = high_time-2, clamped to 0..63.
- factor_ok  output  1  last measurement symmetric and 2 ≤ high_time ≤ 65.
- meas_valid  output  1  one-cycle pulse when all measurement outputs update.
- locked  output  1  two consecutive measurements with identical period.
- stalled  output  1  no edge within TIMEOUT cycles.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - All outputs are 0. Synchronizer and edge-detect flops are 0. Counter is 0. State is WAIT_RISE.
  - Reset overrides every other event, including mid-phase.
- Input path:
  - 2-flop synchronizer, then a third flop for edge detect.
  - rise_s = s2 & ~s3; fall_s = ~s2 & s3.
  - Strobe latency is fixed at 3 clk from the sig_in transition, so differences between strobes equal the true phase lengths.
- Phase counter:
  - Set to 1 on the cycle after any strobe; +1 each cycle otherwise; saturates at 2^CNT_W-1.
  - On a strobe cycle, the pre-strobe value equals the cycles since the previous strobe.
- FSM states: WAIT_RISE, HIGH, LOW.
- WAIT_RISE:
  - Ignores fall_s.
  - On rise_s: go to HIGH and restart the counter.
  - The first partial phase after reset or stall is never measured.
- HIGH:
  - On fall_s: capture cnt into an internal high register, go to LOW.
  - On rise_s (impossible with a clean input): treat as a fresh start and stay in HIGH.
- LOW, on rise_s, all in the same posedge:
  - low_time <= cnt; high_time <= captured high; period <= high+cnt (CNT_W+1 bits, no overflow).
  - div_factor <= clamp(high-2, 0, 63).
  - factor_ok <= (high==cnt) && 2 ≤ high ≤ 65.
  - meas_valid <= 1; stalled <= 0. Next state HIGH.
  - Outputs are registered: visible the cycle after the strobe, together with the meas_valid pulse.
- locked:
  - On each measurement: locked <= (new period == previous measured period) && previous measurement exists since last reset/stall.
  - Any mismatch clears it. Requires 2 identical cycles to reassert.
- Timeout:
  - In any state, if the counter reaches TIMEOUT without a strobe: stalled <= 1, locked <= 0, next state WAIT_RISE, counter restarts.
  - Measurement outputs hold their last values.
  - stalled stays 1 until the next meas_valid.
- Simultaneous timeout and strobe in the same cycle: the strobe wins and the timeout is ignored.
- meas_valid is never high for two consecutive cycles; the minimum measurement spacing is 4 clk (F=0).
- Timing: single clock domain, no combinational path from sig_in to any output. Target 250–350 RTL lines.

Test Plan:
- Divider stimulus F=5 (toggle every 7 clk):
  - high_time=7, low_time=7, period=14, div_factor=5, factor_ok=1.
  - meas_valid every 14 clk; locked=1 on 2nd meas_valid.
- F=0 (toggle every 2 clk): high=low=2, period=4, div_factor=0, factor_ok=1, meas_valid every 4 clk.
- F=63: high=low=65, period=130, div_factor=63.
- Boundary at F=64 equivalent (toggle every 66): div_factor=63, factor_ok=0.
- Asymmetric input (high 3, low 9): period=12, div_factor=1, factor_ok=0, locked=1 after 2nd cycle.
- sig_in held low for 250 clk after lock:
  - stalled=1 exactly TIMEOUT clk after the last strobe, locked=0, outputs held.
  - After restart at F=5: first meas_valid clears stalled.
- Factor change 5→9 mid-stream: locked drops at first 22-clk period, reasserts on 2nd.
- rst_n low for one cycle mid-HIGH: all outputs 0 next cycle; first meas_valid only after a full rise→fall→rise sequence.
